// File: rtl/rgby_rom_pkg.sv
// Shared encodings for the RGBY-ROM program loader: FSM states, error codes, frame magic.
package rgby_rom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_MAGIC   = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [3:0] HDR_MAGIC = 4'hA;

  localparam int NITS_PER_WORD_DEF = 6;

  // States in which cartridge nits are accepted and the load is in progress.
  function automatic logic is_active(state_t s);
    return (s == ST_HDR) || (s == ST_LOAD) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/rom_load_sequencer_nit_packer.sv
// Packs 2-bit colour nits MSB-first into DATA_W-bit words; word_valid pulses the cycle after the last nit.
module nit_packer
  import rgby_rom_pkg::*;
#(
  parameter int NITS   = NITS_PER_WORD_DEF,
  parameter int DATA_W = 2 * NITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic              color_ready,
  input  logic [1:0]        color,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic              partial
);

  localparam int CNT_W = $clog2(NITS + 1);

  logic [CNT_W-1:0] cnt;

  // clear wins over a coincident strobe so a nit arriving with start is dropped
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      word       <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (enable && color_ready) begin
        word <= {word[DATA_W-3:0], color};
        if (cnt == CNT_W'(NITS - 1)) begin
          cnt        <= '0;
          word_valid <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign partial = (cnt != '0);

endmodule

// File: rtl/rom_load_sequencer.sv
// Cartridge program loader: parses header/payload/checksum frames into RAM and releases the CPU on success.
module rom_load_sequencer
  import rgby_rom_pkg::*;
#(
  parameter int NITS_PER_WORD  = NITS_PER_WORD_DEF,
  parameter int DATA_W         = 2 * NITS_PER_WORD,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              color_ready,
  input  logic [1:0]        color,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_run,
  output logic              load_busy,
  output logic              load_error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state;
  logic [DATA_W-1:0] word;
  logic              word_valid;
  logic              partial;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] len_m1;
  logic [DATA_W-1:0] csum;
  logic [TMR_W-1:0]  timer;
  logic              timer_en;
  logic              timeout;
  logic              magic_ok;

  nit_packer #(
    .NITS   (NITS_PER_WORD),
    .DATA_W (DATA_W)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear       (start),
    .enable      (is_active(state)),
    .color_ready (color_ready),
    .color       (color),
    .word        (word),
    .word_valid  (word_valid),
    .partial     (partial)
  );

  // An empty header phase may wait forever; once any nit of a frame arrives the line must keep moving.
  always_comb begin
    timer_en = 1'b0;
    timeout  = 1'b0;
    magic_ok = (word[DATA_W-1 -: 4] == HDR_MAGIC);
    if ((state == ST_LOAD) || (state == ST_CHK) || ((state == ST_HDR) && partial))
      timer_en = 1'b1;
    if (timer_en && !color_ready && (timer == TMR_W'(TIMEOUT_CYCLES - 1)))
      timeout = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      len_m1       <= '0;
      csum         <= '0;
      timer        <= '0;
      ram_we       <= 1'b0;
      ram_waddr    <= '0;
      ram_wdata    <= '0;
      cpu_run      <= 1'b0;
      load_busy    <= 1'b0;
      load_error   <= 1'b0;
      err_code     <= ERR_NONE;
      words_loaded <= '0;
    end else if (start) begin
      // reload from any state; RAM address/data keep the last written value
      state        <= ST_HDR;
      idx          <= '0;
      len_m1       <= '0;
      csum         <= '0;
      timer        <= '0;
      ram_we       <= 1'b0;
      cpu_run      <= 1'b0;
      load_busy    <= 1'b1;
      load_error   <= 1'b0;
      err_code     <= ERR_NONE;
      words_loaded <= '0;
    end else begin
      ram_we <= 1'b0;

      if (color_ready)
        timer <= '0;
      else if (timer_en)
        timer <= timer + TMR_W'(1);

      unique case (state)
        ST_HDR: begin
          if (word_valid) begin
            if (magic_ok) begin
              state  <= ST_LOAD;
              len_m1 <= word[ADDR_W-1:0];
            end else begin
              state      <= ST_ERR;
              load_busy  <= 1'b0;
              load_error <= 1'b1;
              err_code   <= ERR_MAGIC;
            end
          end else if (timeout) begin
            state      <= ST_ERR;
            load_busy  <= 1'b0;
            load_error <= 1'b1;
            err_code   <= ERR_TIMEOUT;
          end
        end

        ST_LOAD: begin
          if (word_valid) begin
            ram_we       <= 1'b1;
            ram_waddr    <= idx;
            ram_wdata    <= word;
            csum         <= csum + word;
            idx          <= idx + ADDR_W'(1);
            words_loaded <= words_loaded + (ADDR_W + 1)'(1);
            if (idx == len_m1)
              state <= ST_CHK;
          end else if (timeout) begin
            state      <= ST_ERR;
            load_busy  <= 1'b0;
            load_error <= 1'b1;
            err_code   <= ERR_TIMEOUT;
          end
        end

        ST_CHK: begin
          if (word_valid) begin
            load_busy <= 1'b0;
            if (word == csum) begin
              state   <= ST_DONE;
              cpu_run <= 1'b1;
            end else begin
              state      <= ST_ERR;
              load_error <= 1'b1;
              err_code   <= ERR_CSUM;
            end
          end else if (timeout) begin
            state      <= ST_ERR;
            load_busy  <= 1'b0;
            load_error <= 1'b1;
            err_code   <= ERR_TIMEOUT;
          end
        end

        ST_ERR: begin
          cpu_run <= 1'b0;
        end

        default: ;
      endcase
    end
  end

endmodule
